// File: rtl/mp_arb_pkg.sv
// Shared types and helpers for the multi-precision adder arbiter.
// Holds the FSM state encoding and the grant-index width helper.
package mp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    localparam int DEF_NUM_REQ = 4;

    // Grant index width; a single requester still needs one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IDX_W = idxWidth(DEF_NUM_REQ);

endpackage

// File: rtl/mp_rr_picker.sv
// Combinational round-robin picker: first set request at or above
// iPtr, wrapping. Ports: iReq, iPtr in; oIdx, oValid out.
module mp_rr_picker
    import mp_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idxWidth(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] iReq,
    input  logic [IDX_W-1:0]   iPtr,
    output logic [IDX_W-1:0]   oIdx,
    output logic               oValid
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        oValid = |iReq;
        oIdx   = '0;
        cand   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(iPtr) + k) % NUM_REQ);
            if (iReq[cand]) begin
                oIdx = cand;
            end
        end
    end

endmodule

// File: rtl/mp_adder_arbiter.sv
// Round-robin arbiter sharing one multi-precision adder among NUM_REQ
// requesters via start/done handshake; returns result with one-hot ack.
// Ports: iClk, iRstn, iReq, iOpA, iOpB, oAck, oRes, oErr, oBusy,
// oAddStart, oAddOpA, oAddOpB, iAddRes, iAddDone.
// Option MP_ARB_TIMEOUT_EN: WAIT watchdog of TIMEOUT_CYCLES, sets oErr.
module mp_adder_arbiter
    import mp_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int OPERAND_WIDTH  = 512,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       iClk,
    input  logic                       iRstn,
    input  logic [NUM_REQ-1:0]         iReq,
    input  logic [NUM_REQ*OPERAND_WIDTH-1:0] iOpA,
    input  logic [NUM_REQ*OPERAND_WIDTH-1:0] iOpB,
    output logic [NUM_REQ-1:0]         oAck,
    output logic [OPERAND_WIDTH:0]     oRes,
    output logic                       oErr,
    output logic                       oBusy,
    output logic                       oAddStart,
    output logic [OPERAND_WIDTH-1:0]   oAddOpA,
    output logic [OPERAND_WIDTH-1:0]   oAddOpB,
    input  logic [OPERAND_WIDTH:0]     iAddRes,
    input  logic                       iAddDone
);

    localparam int IdxW = idxWidth(NUM_REQ);

    state_t state;
    state_t stateNxt;

    logic [IdxW-1:0] ptr;
    logic [IdxW-1:0] grant;
    logic [IdxW-1:0] pickIdx;
    logic            pickValid;
    logic            timeout;

    mp_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IdxW)
    ) uPicker (
        .iReq   (iReq),
        .iPtr   (ptr),
        .oIdx   (pickIdx),
        .oValid (pickValid)
    );

`ifdef MP_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] waitCnt;

    // Cleared while in START so it reads 0 on the first WAIT cycle.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            waitCnt <= '0;
        end else if (state == START) begin
            waitCnt <= '0;
        end else if (state == WAIT) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

    assign timeout = (state == WAIT) &&
                     (waitCnt == CntW'(TIMEOUT_CYCLES - 1));
`else
    logic unusedTimeoutCfg;

    assign unusedTimeoutCfg = (TIMEOUT_CYCLES != 0);
    assign timeout          = 1'b0;
`endif

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt  = state;
        oAddStart = 1'b0;
        oAck      = '0;
        unique case (state)
            IDLE: begin
                if (pickValid) begin
                    stateNxt = START;
                end
            end
            START: begin
                oAddStart = 1'b1;
                stateNxt  = WAIT;
            end
            WAIT: begin
                if (iAddDone || timeout) begin
                    stateNxt = RESP;
                end
            end
            RESP: begin
                oAck[grant] = 1'b1;
                stateNxt    = IDLE;
            end
            default: stateNxt = IDLE;
        endcase
    end

    assign oBusy = (state != IDLE);

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            ptr     <= '0;
            grant   <= '0;
            oAddOpA <= '0;
            oAddOpB <= '0;
            oRes    <= '0;
            oErr    <= 1'b0;
        end else begin
            if (state == IDLE && pickValid) begin
                grant   <= pickIdx;
                oAddOpA <= iOpA[int'(pickIdx)*OPERAND_WIDTH +: OPERAND_WIDTH];
                oAddOpB <= iOpB[int'(pickIdx)*OPERAND_WIDTH +: OPERAND_WIDTH];
            end
            // A done in the final counted cycle beats the watchdog.
            if (state == WAIT) begin
                if (iAddDone) begin
                    oRes <= iAddRes;
                    oErr <= 1'b0;
                end else if (timeout) begin
                    oRes <= '0;
                    oErr <= 1'b1;
                end
            end
            if (state == RESP) begin
                ptr <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mp_adder_arbiter.sv
// Scoreboard bench for mp_adder_arbiter with a behavioural adder stub.
// Round-robin order and sums are predicted from plain arithmetic.
module tb_mp_adder_arbiter;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int TO = 16;
    localparam int RW = W + 1;

    logic           iClk = 1'b0;
    logic           iRstn = 1'b0;
    logic [N-1:0]   iReq;
    logic [N*W-1:0] iOpA;
    logic [N*W-1:0] iOpB;
    logic [N-1:0]   oAck;
    logic [W:0]     oRes;
    logic           oErr;
    logic           oBusy;
    logic           oAddStart;
    logic [W-1:0]   oAddOpA;
    logic [W-1:0]   oAddOpB;
    logic [W:0]     iAddRes;
    logic           iAddDone;

    mp_adder_arbiter #(
        .NUM_REQ        (N),
        .OPERAND_WIDTH  (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .iClk      (iClk),
        .iRstn     (iRstn),
        .iReq      (iReq),
        .iOpA      (iOpA),
        .iOpB      (iOpB),
        .oAck      (oAck),
        .oRes      (oRes),
        .oErr      (oErr),
        .oBusy     (oBusy),
        .oAddStart (oAddStart),
        .oAddOpA   (oAddOpA),
        .oAddOpB   (oAddOpB),
        .iAddRes   (iAddRes),
        .iAddDone  (iAddDone)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    int   errors = 0;
    int   checks = 0;
    int   lat = 3;
    bit   neverDone = 1'b0;
    logic injDone = 1'b0;

    logic       stubBusy;
    logic       stubDone;
    logic [W:0] stubRes;
    int         stubCnt;

    // Adder stub: sums the operands present at done time.
    always @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            stubBusy <= 1'b0;
            stubDone <= 1'b0;
            stubRes  <= '0;
            stubCnt  <= 0;
        end else begin
            stubDone <= 1'b0;
            if (oAddStart) begin
                stubBusy <= 1'b1;
                stubCnt  <= lat;
            end else if (stubBusy && !neverDone) begin
                if (stubCnt <= 1) begin
                    stubBusy <= 1'b0;
                    stubDone <= 1'b1;
                    stubRes  <= {1'b0, oAddOpA} + {1'b0, oAddOpB};
                end else begin
                    stubCnt <= stubCnt - 1;
                end
            end
        end
    end

    assign iAddRes  = stubRes;
    assign iAddDone = stubDone | injDone;

    typedef struct {
        int         idx;
        logic [W:0] res;
        logic       err;
        bit         chkLat;
    } exp_t;

    exp_t       expQ[$];
    logic [W-1:0] mA[N];
    logic [W-1:0] mB[N];
    int         modelPtr = 0;

    task automatic chk(input string nm, input logic [W:0] act,
                       input logic [W:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Monitor: pops one expectation per acknowledge.
    initial begin
        int   starts;
        int   startCyc;
        exp_t e;
        starts   = 0;
        startCyc = 0;
        forever begin
            @(negedge iClk);
            if (!iRstn) begin
                starts = 0;
            end else begin
                if (oAddStart) begin
                    starts++;
                    startCyc = cyc;
                end
                if (oAck != '0) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected ack: got %b expected none",
                                 oAck);
                    end else begin
                        e = expQ.pop_front();
                        chk("ack", RW'(oAck), RW'(1 << e.idx));
                        chk("res", oRes, e.res);
                        chk("err", RW'(oErr), RW'(e.err));
                        chk("starts", RW'(starts), RW'(1));
                        if (e.chkLat) begin
                            chk("timeout latency", RW'(cyc - startCyc),
                                RW'(TO + 1));
                        end
                    end
                    starts = 0;
                end
            end
        end
    end

    task automatic setReq(input int i, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        iOpA[i*W +: W] = a;
        iOpB[i*W +: W] = b;
        mA[i] = a;
        mB[i] = b;
        iReq[i] = 1'b1;
    endtask

    // Reference: pick first pending at/above pointer, wrap, advance.
    task automatic predict(input logic [N-1:0] mask, input int n,
                           input logic [N-1:0] hold);
        logic [N-1:0] s;
        exp_t e;
        int w;
        s = mask;
        repeat (n) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && s[(modelPtr + k) % N]) w = (modelPtr + k) % N;
            end
            if (w < 0) return;
            e.idx    = w;
            e.res    = {1'b0, mA[w]} + {1'b0, mB[w]};
            e.err    = 1'b0;
            e.chkLat = 1'b0;
            expQ.push_back(e);
            if (!hold[w]) s[w] = 1'b0;
            modelPtr = (w + 1) % N;
        end
    endtask

    task automatic waitAcks(input int n, input logic [N-1:0] hold,
                            input int budget);
        int got;
        int t;
        got = 0;
        t   = 0;
        while (got < n && t < budget) begin
            @(negedge iClk);
            t++;
            if (oAck != '0) begin
                got++;
                iReq = iReq & ~(oAck & ~hold);
            end
        end
        if (got < n) begin
            checks++;
            errors++;
            $display("FAIL ack wait: got %0d acks expected %0d", got, n);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit hit, expected completion");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] mask;
        logic [W:0]   prevRes;
        exp_t         e;
        int           t;
        iReq = '0;
        iOpA = '0;
        iOpB = '0;
        repeat (2) @(negedge iClk);
        chk("rst ack", RW'(oAck), RW'(0));
        chk("rst busy", RW'(oBusy), RW'(0));
        chk("rst start", RW'(oAddStart), RW'(0));
        chk("rst res", oRes, RW'(0));
        chk("rst err", RW'(oErr), RW'(0));
        chk("rst opa", RW'(oAddOpA), RW'(0));
        chk("rst opb", RW'(oAddOpB), RW'(0));
        iRstn = 1'b1;
        @(negedge iClk);

        for (int i = 0; i < N; i++) begin
            setReq(i, W'(i + 1), W'(16 * (i + 1)));
        end
        predict(4'b1111, 4, 4'b0000);
        waitAcks(4, 4'b0000, 200);

        setReq(0, {W{1'b1}}, W'(1));
        predict(4'b0001, 1, 4'b0000);
        waitAcks(1, 4'b0000, 100);

        setReq(1, W'(1000), W'(234));
        setReq(2, W'(77), W'(23));
        predict(4'b0110, 4, 4'b0110);
        waitAcks(4, 4'b0110, 400);
        iReq = '0;
        repeat (3) @(negedge iClk);
        chk("idle after hold", RW'(oBusy), RW'(0));

        repeat (6) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            lat  = $urandom_range(1, 6);
            for (int i = 0; i < N; i++) begin
                if (mask[i]) setReq(i, {$urandom, $urandom},
                                    {$urandom, $urandom});
            end
            predict(mask, $countones(mask), 4'b0000);
            waitAcks($countones(mask), 4'b0000, 400);
            repeat (2) @(negedge iClk);
            chk("idle after batch", RW'(oBusy), RW'(0));
        end

        prevRes = oRes;
        injDone = 1'b1;
        @(negedge iClk);
        injDone = 1'b0;
        chk("idle done busy", RW'(oBusy), RW'(0));
        chk("idle done res", oRes, prevRes);
        @(negedge iClk);
        chk("idle done ack", RW'(oAck), RW'(0));

        lat = 4;
        setReq(1, W'(100), W'(200));
        predict(4'b0010, 1, 4'b0000);
        @(negedge iClk);
        chk("start pulse", RW'(oAddStart), RW'(1));
        injDone = 1'b1;
        @(negedge iClk);
        injDone = 1'b0;
        chk("start done ack", RW'(oAck), RW'(0));
        chk("start done busy", RW'(oBusy), RW'(1));
        chk("start single", RW'(oAddStart), RW'(0));
        waitAcks(1, 4'b0000, 100);

        lat = 20;
        setReq(0, W'(11), W'(22));
        t = 0;
        while (!oAddStart && t < 10) begin
            @(negedge iClk);
            t++;
        end
        chk("start before reset", RW'(oAddStart), RW'(1));
        repeat (3) @(negedge iClk);
        #2 iRstn = 1'b0;
        #1;
        chk("midrst ack", RW'(oAck), RW'(0));
        chk("midrst busy", RW'(oBusy), RW'(0));
        chk("midrst start", RW'(oAddStart), RW'(0));
        chk("midrst res", oRes, RW'(0));
        chk("midrst err", RW'(oErr), RW'(0));
        chk("midrst opa", RW'(oAddOpA), RW'(0));
        iReq = '0;
        repeat (2) @(negedge iClk);
        iRstn = 1'b1;
        modelPtr = 0;
        lat = 3;
        @(negedge iClk);
        setReq(3, W'(5), W'(7));
        predict(4'b1000, 1, 4'b0000);
        waitAcks(1, 4'b0000, 100);

`ifdef MP_ARB_TIMEOUT_EN
        neverDone = 1'b1;
        setReq(2, W'(9), W'(9));
        e.idx    = 2;
        e.res    = '0;
        e.err    = 1'b1;
        e.chkLat = 1'b1;
        expQ.push_back(e);
        modelPtr = 3;
        waitAcks(1, 4'b0000, 100);
        neverDone = 1'b0;
        setReq(0, W'(3), W'(4));
        predict(4'b0001, 1, 4'b0000);
        waitAcks(1, 4'b0000, 100);
`endif

        repeat (3) @(negedge iClk);
        chk("queue drained", RW'(expQ.size()), RW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
